// File: rtl/rvv_pkg.sv
// Shared types and constants for the RVV instruction streaming path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvv_pkg;

  // Width of one vector-unit instruction word.
  localparam int RVV_INSN_WIDTH = 32;

  // Bubble presented to the processor whenever no real instruction is available.
  localparam logic [RVV_INSN_WIDTH-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rvv_skid_fifo.sv
// Two-entry FIFO holding instruction words returned from memory.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: full/empty/count exported; a push is accepted when full only if a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   push, push_dat      write strobe and data
//   pop                 remove the head entry
//   full, empty, count  occupancy status (count is 0..2)
//   head                oldest entry (entry 0)
module rvv_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok, push_ok;
  logic [1:0]   cnt_after_pop;

  always_comb begin
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    pop_ok        = pop && (cnt_q != 2'd0);
    push_ok       = push && ((cnt_q != 2'd2) || pop_ok);
    cnt_after_pop = cnt_q - 2'(pop_ok);

    // Pop shifts entry 1 forward; a simultaneous push then lands in the
    // first slot that is free after the shift.
    if (pop_ok) begin
      ent0_d = ent1_q;
    end
    if (push_ok) begin
      if (cnt_after_pop == 2'd0) begin
        ent0_d = push_dat;
      end else begin
        ent1_d = push_dat;
      end
    end
    cnt_d = cnt_after_pop + 2'(push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/rvv_insn_fetch.sv
// Streams insn_count words from instruction memory (addr 0 upward) to the processor insn_in port.
// Latency: start in cycle t -> mem_rd_en at t+1 -> insn_valid at t+2; one word per cycle thereafter.
// Backpressure: stall_in holds insn_out; reads stop once buffered + in-flight words reach 2.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   start, insn_count   launch pulse and program length (sampled when start is accepted)
//   mem_rd_en, mem_addr instruction-memory read request
//   mem_rd_data         read data, returned exactly one cycle after mem_rd_en
//   stall_in            processor cannot take insn_out this cycle
//   insn_out, insn_valid instruction to processor (NOP when not valid)
//   busy, done          streaming in progress / program fully consumed
module rvv_insn_fetch
  import rvv_pkg::*;
#(
  parameter int INSN_WIDTH = RVV_INSN_WIDTH,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] insn_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [INSN_WIDTH-1:0] mem_rd_data,
  input  logic                  stall_in,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid,
  output logic                  busy,
  output logic                  done
);

  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  infl_q, infl_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INSN_WIDTH-1:0] fifo_head;
  logic [1:0]            fifo_count;
  logic                  deliver, bypass, space_ok, last_rd;

  // Words still owed to the processor: buffered plus the one on the memory bus.
  logic [1:0]            pending;
  assign pending = fifo_count + 2'(infl_q);

  always_comb begin
    // The FIFO head is always older than a word arriving from memory, so it
    // has priority; with an empty FIFO the arriving word is presented directly,
    // which is what gives the two-cycle first-word latency.
    insn_valid = !fifo_empty || infl_q;
    insn_out   = INSN_WIDTH'(NOP);
    if (!fifo_empty) begin
      insn_out = fifo_head;
    end else if (infl_q) begin
      insn_out = mem_rd_data;
    end

    deliver   = insn_valid && !stall_in;
    bypass    = fifo_empty && infl_q && deliver;
    fifo_pop  = deliver && !fifo_empty;
    fifo_push = infl_q && !bypass;

    // Issue only while buffered + in-flight < 2 so the returning word always has a slot.
    space_ok  = fifo_empty || (!fifo_full && !infl_q);
    mem_rd_en = (state_q == ST_FETCH) && (rd_ptr_q < cnt_q) && space_ok;
    mem_addr  = mem_rd_en ? rd_ptr_q : '0;
    last_rd   = mem_rd_en && (rd_ptr_q == (cnt_q - ADDR_WIDTH'(1)));
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    infl_d   = mem_rd_en;
    if (mem_rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d    = insn_count;
          rd_ptr_d = '0;
          state_d  = (insn_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (last_rd) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Final word leaves this cycle; nothing else is buffered or in flight.
        if (deliver && (pending == 2'd1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
    end
  end

  assign busy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  rvv_skid_fifo #(
    .W (INSN_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (fifo_push),
    .push_dat (mem_rd_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_rvv_insn_fetch.sv
// Directed bench for rvv_insn_fetch with a one-cycle-latency memory model and a delivery scoreboard.
// Latency: n/a.
// Backpressure: stall_in driven per test (fixed windows or random).
module tb_rvv_insn_fetch;

  localparam int IW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall_in = 1'b0;
  logic [AW-1:0] insn_count = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rd_data;
  logic [IW-1:0] insn_out;
  logic          insn_valid, busy, done;

  logic [IW-1:0] mem [0:127];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvv_insn_fetch #(
    .INSN_WIDTH (IW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .insn_count  (insn_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .stall_in    (stall_in),
    .insn_out    (insn_out),
    .insn_valid  (insn_valid),
    .busy        (busy),
    .done        (done)
  );

  // Synchronous-read memory; garbage on the bus when no read was issued.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_addr] : 32'hDEAD_BEEF;
  end

  // Scoreboard: records every consumed word, read-address order and outstanding words.
  logic [IW-1:0] got[$];
  int   issued, consumed, exp_addr, bad_addr, bad_occ;
  logic mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got.delete();
      issued   = 0;
      consumed = 0;
      exp_addr = 0;
      bad_addr = 0;
      bad_occ  = 0;
    end else if (rst) begin
      if (mem_rd_en) begin
        if (int'(mem_addr) != exp_addr) bad_addr++;
        if (issued - consumed >= 2) bad_occ++;
        exp_addr++;
        issued++;
      end
      if (insn_valid && !stall_in) begin
        got.push_back(insn_out);
        consumed++;
      end
      if (issued - consumed > 2) bad_occ++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  // Pulses start for one cycle (cycle t); returns 1ns into cycle t+1.
  task automatic start_pulse(input int n);
    start      = 1'b1;
    insn_count = AW'(n);
    tick();
    start      = 1'b0;
    insn_count = '0;
  endtask

  task automatic wait_done(input int budget, input logic rnd, input string tag);
    int k = 0;
    while (!done && k < budget) begin
      stall_in = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      k++;
    end
    stall_in = 1'b0;
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n);
    int nbad = 0;
    chk({tag, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < got.size() && i < n; i++) begin
      if (got[i] !== mem[i]) nbad++;
    end
    chk({tag, "_data"}, 32'(nbad), 32'd0);
    chk({tag, "_addr"}, 32'(bad_addr), 32'd0);
    chk({tag, "_occ"}, 32'(bad_occ), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},   insn_out,           32'd0);
    chk({tag, "_valid"}, 32'(insn_valid),    32'd0);
    chk({tag, "_rden"},  32'(mem_rd_en),     32'd0);
    chk({tag, "_addr0"}, 32'(mem_addr),      32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    mem[0] = 32'h5c00_00d7;
    mem[1] = 32'h0011_0257;
    mem[2] = 32'h0001_82d7;

    // Reset state
    #12;
    chk_all_zero("rst");
    tick();
    rst = 1'b1;
    tick();

    // 3-word stream, no stall: valid t+2..t+4, done t+5
    clear_mon();
    tick();
    start_pulse(3);
    chk("t1_rden_t1", 32'(mem_rd_en), 32'd1);
    chk("t1_addr_t1", 32'(mem_addr), 32'd0);
    chk("t1_valid_t1", 32'(insn_valid), 32'd0);
    chk("t1_busy_t1", 32'(busy), 32'd1);
    tick();
    chk("t1_valid_t2", 32'(insn_valid), 32'd1);
    chk("t1_w0", insn_out, 32'h5c00_00d7);
    tick();
    chk("t1_w1", insn_out, 32'h0011_0257);
    tick();
    chk("t1_w2", insn_out, 32'h0001_82d7);
    chk("t1_done_t4", 32'(done), 32'd0);
    tick();
    chk("t1_done_t5", 32'(done), 32'd1);
    chk("t1_valid_t5", 32'(insn_valid), 32'd0);
    chk("t1_nop_t5", insn_out, 32'd0);
    chk("t1_busy_t5", 32'(busy), 32'd0);
    check_stream("t1", 3);

    // 38 words, stall t+3..t+6: second word held, reads stop while full
    clear_mon();
    tick();
    start_pulse(38);
    for (int k = 1; k <= 8; k++) begin
      stall_in = (k >= 3 && k <= 6);
      if (k == 3) chk("t2_rden_t3", 32'(mem_rd_en), 32'd1);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("t2_hold_t%0d", k), insn_out, mem[1]);
        chk($sformatf("t2_valid_t%0d", k), 32'(insn_valid), 32'd1);
      end
      if (k == 5 || k == 6) chk($sformatf("t2_rden_full_t%0d", k), 32'(mem_rd_en), 32'd0);
      tick();
    end
    stall_in = 1'b0;
    wait_done(300, 1'b0, "t2_done");
    check_stream("t2", 38);

    // Zero-length program: done at t+1, no reads, NOP out
    clear_mon();
    tick();
    start_pulse(0);
    chk("t3_done_t1", 32'(done), 32'd1);
    chk("t3_rden_t1", 32'(mem_rd_en), 32'd0);
    chk("t3_nop_t1", insn_out, 32'd0);
    tick();
    tick();
    chk("t3_no_reads", 32'(issued), 32'd0);
    chk("t3_done_held", 32'(done), 32'd1);

    // Reset at third delivered word of a 10-word run, then restart
    clear_mon();
    tick();
    start_pulse(10);
    tick();
    tick();
    tick();
    chk("t4_w2_pre", insn_out, mem[2]);
    chk("t4_valid_pre", 32'(insn_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("t4_rst");
    tick();
    tick();
    rst = 1'b1;
    clear_mon();
    tick();
    start_pulse(10);
    chk("t4_restart_rden", 32'(mem_rd_en), 32'd1);
    chk("t4_restart_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("t4_restart_w0", insn_out, mem[0]);
    wait_done(200, 1'b0, "t4_done");
    check_stream("t4", 10);

    // Start during FETCH ignored; start from DONE relaunches
    clear_mon();
    tick();
    start_pulse(4);
    start      = 1'b1;
    insn_count = AW'(9);
    tick();
    start      = 1'b0;
    insn_count = '0;
    wait_done(200, 1'b0, "t5a_done");
    check_stream("t5a", 4);
    clear_mon();
    tick();
    chk("t5_done_before", 32'(done), 32'd1);
    start_pulse(2);
    chk("t5_done_cleared", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_done(200, 1'b0, "t5b_done");
    check_stream("t5b", 2);

    // 100 words under random 50% stall
    clear_mon();
    tick();
    start_pulse(100);
    wait_done(2000, 1'b1, "t6_done");
    check_stream("t6", 100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
